// File: rtl/led_pong_game_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pong_game_if
// Description : Button inputs and LED/score outputs of the two-player pong game.
// Revision    : 1.0
// ============================================================================
interface led_pong_game_if #(
  parameter int N_LEDS  = 4,
  parameter int SCORE_W = 4
);
  logic               start_i;
  logic               play_l_i;
  logic               play_r_i;
  logic [N_LEDS-1:0]  ld_o;
  logic [SCORE_W-1:0] score_l_o;
  logic [SCORE_W-1:0] score_r_o;
  logic               game_over_o;
  logic               winner_o;

  modport master (
    output start_i, play_l_i, play_r_i,
    input  ld_o, score_l_o, score_r_o, game_over_o, winner_o
  );

  modport slave (
    input  start_i, play_l_i, play_r_i,
    output ld_o, score_l_o, score_r_o, game_over_o, winner_o
  );
endinterface
`default_nettype wire

// File: rtl/led_pong_game.sv
`default_nettype none
// ============================================================================
// Module      : led_pong_game
// Description : Two-player LED pong with miss blink and game-over display.
//               Optional macro SPEEDUP_EN shortens the tick period per return.
// Revision    : 1.0
// ============================================================================
module led_pong_game #(
  parameter int N_LEDS      = 4,
  parameter int TICK_DIV    = 25_000_000,
  parameter int BLINK_TICKS = 6,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 4,
  parameter int SPEED_STEP  = 2_000_000,
  parameter int TICK_MIN    = 5_000_000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  led_pong_game_if.slave bus
);

  localparam int PW = $clog2(N_LEDS);
  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0]      LAST  = PW'(N_LEDS - 1);
  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
  localparam logic               DIR_R = 1'b0;

  if ((N_LEDS < 2) || (TICK_DIV < 2) || (WIN_SCORE >= (1 << SCORE_W)) ||
      (SPEED_STEP < 0) || (TICK_MIN < 1)) begin : g_bad_cfg
    $error("led_pong_game: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MISS = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;
  logic               hit_q, hit_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW-1:0]      blink_q, blink_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [N_LEDS-1:0]  ld_q, ld_d;
  logic               game_over_q, game_over_d;
  logic               winner_q, winner_d;
  logic [CW-1:0]      period_w;
  logic               tick_w;
  logic               at_end_w;
  logic               press_w;
  logic               hit_w;

`ifdef SPEEDUP_EN
  logic [CW-1:0] period_q, period_d;

  // Every entry into RUN is a serve and restores the slow period.
  always_comb begin
    period_d = period_q;
    if ((state_d == S_RUN) && (state_q != S_RUN)) begin
      period_d = CW'(TICK_DIV);
    end else if ((state_q == S_RUN) && tick_w && at_end_w && hit_w) begin
      if (int'(period_q) > (TICK_MIN + SPEED_STEP)) begin
        period_d = period_q - CW'(SPEED_STEP);
      end else begin
        period_d = CW'(TICK_MIN);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      period_q <= CW'(TICK_DIV);
    end else begin
      period_q <= period_d;
    end
  end

  assign period_w = period_q;
`else
  assign period_w = CW'(TICK_DIV);
`endif

  assign tick_w   = (state_q != S_IDLE) && (cnt_q == (period_w - CW'(1)));
  assign at_end_w = (dir_q == DIR_R) ? (pos_q == '0) : (pos_q == LAST);
  assign press_w  = (dir_q == DIR_R) ? bus.play_r_i : bus.play_l_i;
  assign hit_w    = hit_q || (at_end_w && press_w);

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    hit_d     = 1'b0;
    blink_d   = blink_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = tick_w ? '0 : cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start_i) begin
          state_d = S_RUN;
          pos_d   = LAST;
          dir_d   = DIR_R;
        end
      end
      S_RUN: begin
        hit_d = hit_w;
        if (tick_w) begin
          hit_d = 1'b0;
          if (!at_end_w) begin
            pos_d = (dir_q == DIR_R) ? pos_q - PW'(1) : pos_q + PW'(1);
          end else if (hit_w) begin
            dir_d = ~dir_q;
            pos_d = (dir_q == DIR_R) ? PW'(1) : LAST - PW'(1);
          end else begin
            state_d = S_MISS;
            if (dir_q == DIR_R) begin
              score_l_d = (score_l_q < WIN) ? score_l_q + SCORE_W'(1) : score_l_q;
            end else begin
              score_r_d = (score_r_q < WIN) ? score_r_q + SCORE_W'(1) : score_r_q;
            end
          end
        end
      end
      S_MISS: begin
        // dir still points at the player who missed; serve from that end.
        if (tick_w) begin
          if (blink_q == BW'(BLINK_TICKS - 1)) begin
            if ((score_l_q == WIN) || (score_r_q == WIN)) begin
              state_d = S_OVER;
            end else begin
              state_d = S_RUN;
              pos_d   = (dir_q == DIR_R) ? '0 : LAST;
              dir_d   = ~dir_q;
            end
          end else begin
            blink_d = blink_q + BW'(1);
          end
        end
      end
      S_OVER: begin
        if (bus.start_i) begin
          state_d   = S_RUN;
          pos_d     = LAST;
          dir_d     = DIR_R;
          score_l_d = '0;
          score_r_d = '0;
        end else if (tick_w) begin
          blink_d = blink_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d   = '0;
      blink_d = '0;
      hit_d   = 1'b0;
    end

    ld_d = '0;
    case (state_d)
      S_RUN:          ld_d = N_LEDS'(1) << pos_d;
      S_MISS, S_OVER: ld_d = blink_d[0] ? '0 : '1;
      default:        ld_d = '0;
    endcase
    game_over_d = (state_d == S_OVER);
    winner_d    = (state_d == S_OVER) && (score_r_d == WIN);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pos_q       <= LAST;
      dir_q       <= DIR_R;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      blink_q     <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      ld_q        <= '0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      hit_q       <= hit_d;
      cnt_q       <= cnt_d;
      blink_q     <= blink_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      ld_q        <= ld_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.ld_o        = ld_q;
  assign bus.score_l_o   = score_l_q;
  assign bus.score_r_o   = score_r_q;
  assign bus.game_over_o = game_over_q;
  assign bus.winner_o    = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pong_game.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pong_game
// Description : Directed game scenario checked every cycle against a rule model.
// Revision    : 1.0
// ============================================================================
module tb_led_pong_game;

  localparam int N_LEDS      = 4;
  localparam int BLINK_TICKS = 4;
  localparam int WIN_SCORE   = 2;
  localparam int SCORE_W     = 4;
`ifdef SPEEDUP_EN
  localparam int TICK_DIV    = 8;
  localparam int SPEED_STEP  = 2;
  localparam int TICK_MIN    = 4;
  localparam int RET_PERIOD  = 6;
`else
  localparam int TICK_DIV    = 4;
  localparam int SPEED_STEP  = 2;
  localparam int TICK_MIN    = 1;
  localparam int RET_PERIOD  = 4;
`endif
  localparam int BUDGET = 12 * TICK_DIV;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  led_pong_game_if #(.N_LEDS(N_LEDS), .SCORE_W(SCORE_W)) bus ();

  led_pong_game #(
    .N_LEDS(N_LEDS), .TICK_DIV(TICK_DIV), .BLINK_TICKS(BLINK_TICKS),
    .WIN_SCORE(WIN_SCORE), .SCORE_W(SCORE_W),
    .SPEED_STEP(SPEED_STEP), .TICK_MIN(TICK_MIN)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules model: state 0 idle, 1 run, 2 miss, 3 game over; dir -1 = rightward.
  int m_state, m_pos, m_dir, m_hit, m_left, m_ticks, m_sl, m_sr, m_period;
  bit m_valid = 1'b0;
  logic [N_LEDS-1:0] m_ld;
  logic m_over, m_win;

  task automatic m_enter(input int s);
    m_state = s;
    m_left  = m_period;
    m_ticks = 0;
    m_hit   = 0;
  endtask

  always @(posedge clk) begin
    bit tk;
    int end_pos;
    bit press;
    tk = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_pos = N_LEDS - 1; m_dir = -1; m_hit = 0; m_left = 0;
      m_ticks = 0; m_sl = 0; m_sr = 0; m_period = TICK_DIV;
    end else begin
      if (m_state != 0) begin
        m_left--;
        tk = (m_left == 0);
      end
      case (m_state)
        0: if (bus.start_i) begin
          m_pos = N_LEDS - 1; m_dir = -1; m_period = TICK_DIV; m_enter(1);
        end
        1: begin
          end_pos = (m_dir < 0) ? 0 : N_LEDS - 1;
          press   = (m_dir < 0) ? bus.play_r_i : bus.play_l_i;
          if (m_pos == end_pos && press) m_hit = 1;
          if (tk) begin
            if (m_pos != end_pos) begin
              m_pos += m_dir; m_hit = 0;
            end else if (m_hit != 0) begin
              m_dir = -m_dir; m_pos += m_dir; m_hit = 0;
`ifdef SPEEDUP_EN
              m_period = (m_period - SPEED_STEP < TICK_MIN) ? TICK_MIN : m_period - SPEED_STEP;
`endif
            end else begin
              if (m_dir < 0) m_sl = (m_sl + 1 > WIN_SCORE) ? WIN_SCORE : m_sl + 1;
              else           m_sr = (m_sr + 1 > WIN_SCORE) ? WIN_SCORE : m_sr + 1;
              m_enter(2);
            end
          end
        end
        2: if (tk) begin
          m_ticks++;
          if (m_ticks == BLINK_TICKS) begin
            if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) m_enter(3);
            else begin
              m_pos = (m_dir < 0) ? 0 : N_LEDS - 1;
              m_dir = -m_dir; m_period = TICK_DIV; m_enter(1);
            end
          end
        end
        default: if (bus.start_i) begin
          m_sl = 0; m_sr = 0; m_pos = N_LEDS - 1; m_dir = -1;
          m_period = TICK_DIV; m_enter(1);
        end else if (tk) m_ticks++;
      endcase
      if (tk) m_left = m_period;
    end
    case (m_state)
      1:       m_ld = N_LEDS'(1 << m_pos);
      2, 3:    m_ld = (m_ticks % 2 == 1) ? '0 : '1;
      default: m_ld = '0;
    endcase
    m_over  = (m_state == 3);
    m_win   = m_over && (m_sr == WIN_SCORE);
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_ld",        int'(bus.ld_o),        int'(m_ld));
      chk("cyc_score_l",   int'(bus.score_l_o),   m_sl);
      chk("cyc_score_r",   int'(bus.score_r_o),   m_sr);
      chk("cyc_game_over", int'(bus.game_over_o), int'(m_over));
      chk("cyc_winner",    int'(bus.winner_o),    int'(m_win));
    end
  end

  task automatic wait_ld(input logic [N_LEDS-1:0] v, output int n);
    n = 0;
    while (bus.ld_o !== v && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ld", int'(bus.ld_o), int'(v));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.play_l_i = 1'b0; bus.play_r_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ld", int'(bus.ld_o), 0);
    chk("reset_scores", int'(bus.score_l_o) + int'(bus.score_r_o), 0);
    chk("reset_over", int'(bus.game_over_o), 0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.play_l_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("start_ld", int'(bus.ld_o), 8);
    wait_ld(4'b0100, n);
    bus.play_l_i = 1'b0;
    wait_ld(4'b0010, n);
    chk("step_period", n, TICK_DIV);
    wait_ld(4'b0001, n);
    bus.play_l_i = 1'b1; bus.play_r_i = 1'b1;
    wait_ld(4'b0010, n);
    bus.play_l_i = 1'b0; bus.play_r_i = 1'b0;
    chk("return_score_l", int'(bus.score_l_o), 0);
    wait_ld(4'b0100, n);
    chk("return_period", n, RET_PERIOD);
    wait_ld(4'b1000, n);
    bus.play_l_i = 1'b1;
    wait_ld(4'b0100, n);
    bus.play_l_i = 1'b0;
    wait_ld(4'b0010, n);
    wait_ld(4'b0001, n);
    wait_ld(4'b1111, n);
    chk("miss1_score_l", int'(bus.score_l_o), 1);
    chk("miss1_score_r", int'(bus.score_r_o), 0);
    wait_ld(4'b0000, n);
    chk("blink_period", n, TICK_DIV);
    wait_ld(4'b1111, n);
    wait_ld(4'b0000, n);
    wait_ld(4'b0001, n);
    chk("serve_right_over", int'(bus.game_over_o), 0);
    wait_ld(4'b0010, n);
    wait_ld(4'b0100, n);
    wait_ld(4'b1000, n);
    bus.play_l_i = 1'b1;
    wait_ld(4'b0100, n);
    bus.play_l_i = 1'b0;
    wait_ld(4'b0010, n);
    bus.play_r_i = 1'b1;
    repeat (2) @(negedge clk);
    bus.play_r_i = 1'b0;
    wait_ld(4'b0001, n);
    wait_ld(4'b1111, n);
    chk("early_press_score_l", int'(bus.score_l_o), 2);
    n = 0;
    while (bus.game_over_o !== 1'b1 && n < 2 * BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("game_over", int'(bus.game_over_o), 1);
    chk("winner_left", int'(bus.winner_o), 0);
    chk("over_ld_on", int'(bus.ld_o), 15);
    wait_ld(4'b0000, n);
    wait_ld(4'b1111, n);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("restart_ld", int'(bus.ld_o), 8);
    chk("restart_scores", int'(bus.score_l_o) + int'(bus.score_r_o), 0);
    chk("restart_over", int'(bus.game_over_o), 0);
    wait_ld(4'b0001, n);
    bus.play_r_i = 1'b1;
    wait_ld(4'b0010, n);
    bus.play_r_i = 1'b0;
    wait_ld(4'b0100, n);
    wait_ld(4'b1000, n);
    wait_ld(4'b1111, n);
    chk("miss2_score_r", int'(bus.score_r_o), 1);
    wait_ld(4'b0000, n);
    wait_ld(4'b1111, n);
    wait_ld(4'b0000, n);
    wait_ld(4'b1000, n);
    wait_ld(4'b0100, n);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midgame_reset_ld", int'(bus.ld_o), 0);
    chk("midgame_reset_score_r", int'(bus.score_r_o), 0);
    rst_n = 1'b1;
    repeat (3 * TICK_DIV) @(negedge clk);
    chk("idle_needs_start", int'(bus.ld_o), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
